// File: rtl/sdram_slave_responder_pkg.sv
// sdram_resp_pkg: widths, FSM states and stall-LFSR constants shared by sdram_slave_responder.
package sdram_resp_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 32;
    localparam int BE_W = 2;
    typedef logic signed [DATA_W-1:0] data_t;
    typedef enum logic {S_INIT, S_RUN} state_t;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
endpackage

// File: rtl/sdram_slave_responder_if.sv
// sdram_slave_responder_if: Avalon-MM pipelined bus with active-low read_n/write_n strobes.
interface sdram_slave_responder_if;
    import sdram_resp_pkg::*;
    logic chipselect;
    logic read_n;
    logic write_n;
    logic [ADDR_W-1:0] address;
    logic [BE_W-1:0] byteenable;
    data_t writedata;
    logic waitrequest;
    logic readdatavalid;
    data_t readdata;
    modport master (
        output chipselect, read_n, write_n, address, byteenable, writedata,
        input waitrequest, readdatavalid, readdata
    );
    modport slave (
        input chipselect, read_n, write_n, address, byteenable, writedata,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/sdram_slave_responder_read_pipe.sv
// resp_read_pipe: fixed-latency shift of {valid,data}; reset flushes every stage.
module resp_read_pipe
    import sdram_resp_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  in_valid,
    input  data_t in_data,
    output logic  out_valid,
    output data_t out_data
);
    logic v [LAT];
    data_t d [LAT];
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                v[i] <= 1'b0;
                d[i] <= '0;
            end
        end else begin
            v[0] <= in_valid;
            d[0] <= in_data;
            for (int i = 1; i < LAT; i++) begin
                v[i] <= v[i-1];
                d[i] <= d[i-1];
            end
        end
    end
    assign out_valid = v[LAT-1];
    assign out_data = d[LAT-1];
endmodule

// File: rtl/sdram_slave_responder.sv
// sdram_slave_responder: Avalon-MM slave word memory with fixed read latency and clear-on-reset.
// Define RESP_RANDOM_STALL_EN to add LFSR-driven waitrequest stalls in S_RUN.
module sdram_slave_responder
    import sdram_resp_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int READ_LATENCY = 3,
    parameter int MAX_PENDING = 3
) (
    input  logic clk,
    input  logic reset,
    sdram_slave_responder_if.slave bus,
    output logic init_done,
    output logic [DATA_W-1:0] err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam int OW = ADDR_W + 1;
    state_t state;
    logic [AW-1:0] init_cnt;
    logic [PW-1:0] pending;
    logic [OW-1:0] off;
    data_t mem [DEPTH];
    logic acc, both, in_range, rd_acc, wr_ok, err;
    // A negative offset wraps to a huge value, so one compare covers both range ends.
    assign off = {1'b0, bus.address} - {1'b0, BASE_ADDR};
    assign in_range = off < OW'(DEPTH);
    assign acc = bus.chipselect & ~bus.waitrequest & (~bus.read_n | ~bus.write_n);
    assign both = ~bus.read_n & ~bus.write_n;
    assign rd_acc = acc & ~bus.read_n & bus.write_n & ~reset;
    assign wr_ok = acc & bus.read_n & ~bus.write_n & in_range & ~reset;
    assign err = acc & (both | ~in_range);
`ifdef RESP_RANDOM_STALL_EN
    logic [15:0] lfsr;
    always_ff @(posedge clk) lfsr <= reset ? LFSR_SEED : {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
    assign bus.waitrequest = (state == S_INIT) | (pending == PW'(MAX_PENDING)) | (lfsr[1:0] == 2'b00);
`else
    assign bus.waitrequest = (state == S_INIT) | (pending == PW'(MAX_PENDING));
`endif
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT;
            init_cnt <= '0;
            init_done <= 1'b0;
            pending <= '0;
            err_cnt <= '0;
        end else begin
            init_cnt <= (state == S_INIT) ? init_cnt + 1'b1 : init_cnt;
            if (state == S_INIT && init_cnt == AW'(DEPTH - 1)) begin
                state <= S_RUN;
                init_done <= 1'b1;
            end
            pending <= pending + PW'(rd_acc) - PW'(bus.readdatavalid);
            err_cnt <= (err && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
        end
    end
    always_ff @(posedge clk) begin
        if (!reset && state == S_INIT) mem[init_cnt] <= '0;
        else if (wr_ok) begin
            if (bus.byteenable[0]) mem[off[AW-1:0]][7:0] <= bus.writedata[7:0];
            if (bus.byteenable[1]) mem[off[AW-1:0]][15:8] <= bus.writedata[15:8];
        end
    end
    resp_read_pipe #(.LAT(READ_LATENCY)) u_pipe (
        .clk(clk),
        .reset(reset),
        .in_valid(rd_acc),
        .in_data(in_range ? mem[off[AW-1:0]] : '0),
        .out_valid(bus.readdatavalid),
        .out_data(bus.readdata)
    );
endmodule

// File: tb/tb_sdram_slave_responder.sv
// tb_sdram_slave_responder: randomized scenarios checked against a word-array memory model.
module tb_sdram_slave_responder;
    import sdram_resp_pkg::*;
    localparam int DEPTH = 1024;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int LAT = 3;
    localparam int MAXP = 2;
    typedef struct {logic [15:0] d; int c;} beat_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic init_done;
    logic [15:0] err_cnt;
    int cyc = 0, n_tests = 0, n_fail = 0, m_err = 0;
    logic [15:0] m [DEPTH];
    beat_t exp_q[$], obs_q[$];
    sdram_slave_responder_if bus();
    sdram_slave_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LATENCY(LAT), .MAX_PENDING(MAXP)) dut (
        .clk(clk), .reset(reset), .bus(bus), .init_done(init_done), .err_cnt(err_cnt)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (bus.readdatavalid) obs_q.push_back('{bus.readdata, cyc});

    task automatic idle();
        bus.chipselect = 1'b0;
        bus.read_n = 1'b1;
        bus.write_n = 1'b1;
        bus.address = '0;
        bus.byteenable = '0;
        bus.writedata = '0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m[i] = 16'h0;
        m_err = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // Holds the command until accepted, then applies the spec's effect to the model.
    task automatic issue(input logic rn, input logic wn, input logic [31:0] a,
                         input logic [1:0] be, input logic [15:0] wd, output int stalls);
        logic [31:0] off;
        bit hit;
        bus.chipselect = 1'b1;
        bus.read_n = rn;
        bus.write_n = wn;
        bus.address = a;
        bus.byteenable = be;
        bus.writedata = wd;
        stalls = 0;
        while (bus.waitrequest && stalls < 100) begin
            @(negedge clk);
            stalls++;
        end
        if (stalls >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout addr=%h waitrequest stayed 1, want 0 within 100 cycles", a);
        end else begin
            off = a - BASE;
            hit = (a >= BASE) && (off < DEPTH);
            if (!rn && !wn) m_err = (m_err < 65535) ? m_err + 1 : m_err;
            else if (!rn) begin
                exp_q.push_back('{hit ? m[off[9:0]] : 16'h0, cyc + LAT});
                if (!hit) m_err = (m_err < 65535) ? m_err + 1 : m_err;
            end else if (hit) begin
                if (be[0]) m[off[9:0]][7:0] = wd[7:0];
                if (be[1]) m[off[9:0]][15:8] = wd[15:8];
            end else m_err = (m_err < 65535) ? m_err + 1 : m_err;
        end
        @(negedge clk);
        idle();
    endtask

    task automatic drain(output bit ok);
        int t = 0;
        while (obs_q.size() < exp_q.size() && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (LAT + 1) @(negedge clk);
        ok = (t < 50);
    endtask

    task automatic test_reset();
        int n = 0, s;
        bit ok;
        reset = 1'b1;
        idle();
        model_reset();
        repeat (3) @(negedge clk);
        n_tests += 5;
        if (bus.waitrequest !== 1'b1) begin n_fail++; $display("FAIL rst_waitrequest got %b want 1", bus.waitrequest); end
        if (bus.readdatavalid !== 1'b0) begin n_fail++; $display("FAIL rst_readdatavalid got %b want 0", bus.readdatavalid); end
        if (bus.readdata !== 16'h0) begin n_fail++; $display("FAIL rst_readdata got %h want 0000", bus.readdata); end
        if (init_done !== 1'b0) begin n_fail++; $display("FAIL rst_init_done got %b want 0", init_done); end
        if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL rst_err_cnt got %h want 0000", err_cnt); end
        reset = 1'b0;
        while (bus.waitrequest && n < 2000) begin
            n++;
            @(negedge clk);
        end
        n_tests += 2;
        if (n != DEPTH) begin n_fail++; $display("FAIL init_cycles got %0d want %0d", n, DEPTH); end
        if (init_done !== 1'b1) begin n_fail++; $display("FAIL init_done got %b want 1", init_done); end
        obs_q.delete();
        issue(1'b0, 1'b1, BASE + 5, 2'b11, 16'h0, s);
        drain(ok);
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL init_read_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_tests++;
            if (obs_q[i].d !== exp_q[i].d || obs_q[i].c != exp_q[i].c) begin
                n_fail++; $display("FAIL init_read beat%0d got %h@%0d want %h@%0d", i, obs_q[i].d, obs_q[i].c, exp_q[i].d, exp_q[i].c);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_write_read();
        int s;
        bit ok;
        issue(1'b1, 1'b0, BASE + 3, 2'b11, 16'h1234, s);
        issue(1'b0, 1'b1, BASE + 3, 2'b00, 16'h0, s);
        issue(1'b1, 1'b0, BASE + 3, 2'b01, 16'hABCD, s);
        issue(1'b0, 1'b1, BASE + 3, 2'b00, 16'h0, s);
        issue(1'b1, 1'b0, BASE + 3, 2'b00, 16'hFFFF, s);
        issue(1'b0, 1'b1, BASE + 3, 2'b00, 16'h0, s);
        issue(1'b1, 1'b0, BASE + 9, 2'b10, 16'h5A77, s);
        issue(1'b0, 1'b1, BASE + 9, 2'b00, 16'h0, s);
        drain(ok);
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL wr_rd_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_tests++;
            if (obs_q[i].d !== exp_q[i].d || obs_q[i].c != exp_q[i].c) begin
                n_fail++; $display("FAIL wr_rd beat%0d got %h@%0d want %h@%0d", i, obs_q[i].d, obs_q[i].c, exp_q[i].d, exp_q[i].c);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        int st [4];
        bit ok;
        for (int i = 0; i < 4; i++) issue(1'b1, 1'b0, BASE + i, 2'b11, 16'h000A + 16'(i), st[0]);
        for (int i = 0; i < 4; i++) issue(1'b0, 1'b1, BASE + i, 2'b00, 16'h0, st[i]);
        n_tests += 2;
        if (st[0] != 0 || st[1] != 0) begin n_fail++; $display("FAIL b2b_early_stall got %0d,%0d want 0,0", st[0], st[1]); end
        if (st[2] == 0) begin n_fail++; $display("FAIL b2b_limit_stall got %0d want >0 after %0d accepts", st[2], MAXP); end
        drain(ok);
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL b2b_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_tests++;
            if (obs_q[i].d !== exp_q[i].d || obs_q[i].c != exp_q[i].c) begin
                n_fail++; $display("FAIL b2b beat%0d got %h@%0d want %h@%0d", i, obs_q[i].d, obs_q[i].c, exp_q[i].d, exp_q[i].c);
            end
        end
        n_tests++;
        if (bus.waitrequest !== 1'b0) begin n_fail++; $display("FAIL b2b_pending_idle waitrequest got %b want 0", bus.waitrequest); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_errors();
        int s;
        bit ok;
        issue(1'b0, 1'b0, BASE + 3, 2'b11, 16'h7777, s);
        issue(1'b0, 1'b1, BASE + DEPTH, 2'b00, 16'h0, s);
        issue(1'b0, 1'b1, BASE + 3, 2'b00, 16'h0, s);
        n_tests++;
        if (err_cnt !== 16'(m_err)) begin n_fail++; $display("FAIL err_cnt_two got %0d want %0d", err_cnt, m_err); end
        issue(1'b1, 1'b0, BASE - 1, 2'b11, 16'h4444, s);
        issue(1'b0, 1'b1, BASE - 1, 2'b00, 16'h0, s);
        drain(ok);
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL err_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_tests++;
            if (obs_q[i].d !== exp_q[i].d || obs_q[i].c != exp_q[i].c) begin
                n_fail++; $display("FAIL err beat%0d got %h@%0d want %h@%0d", i, obs_q[i].d, obs_q[i].c, exp_q[i].d, exp_q[i].c);
            end
        end
        n_tests++;
        if (err_cnt !== 16'(m_err)) begin n_fail++; $display("FAIL err_cnt got %0d want %0d", err_cnt, m_err); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random();
        int s, r, k;
        logic [31:0] a;
        bit ok;
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            k = $urandom_range(0, 9);
            a = (r < 8) ? BASE + $urandom_range(0, 15) : (r == 8) ? BASE + DEPTH + $urandom_range(0, 3) : BASE - 1 - $urandom_range(0, 3);
            issue(k == 0 ? 1'b0 : (k < 5), k == 0 ? 1'b0 : (k >= 5), a, 2'($urandom), 16'($urandom), s);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain(ok);
        n_tests++;
        if (!ok || obs_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_count got %0d want %0d", obs_q.size(), exp_q.size()); end
        else foreach (exp_q[i]) begin
            n_tests++;
            if (obs_q[i].d !== exp_q[i].d || obs_q[i].c != exp_q[i].c) begin
                n_fail++; $display("FAIL rand beat%0d got %h@%0d want %h@%0d", i, obs_q[i].d, obs_q[i].c, exp_q[i].d, exp_q[i].c);
            end
        end
        n_tests++;
        if (err_cnt !== 16'(m_err)) begin n_fail++; $display("FAIL rand_err_cnt got %0d want %0d", err_cnt, m_err); end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_flight();
        int s, n = 0, bad = 0;
        bit ok;
        issue(1'b0, 1'b1, BASE + 3, 2'b00, 16'h0, s);
        issue(1'b0, 1'b1, BASE + 9, 2'b00, 16'h0, s);
        reset = 1'b1;
        model_reset();
        @(negedge clk);
        n_tests++;
        if (bus.readdatavalid !== 1'b0) begin n_fail++; $display("FAIL flight_valid got %b want 0", bus.readdatavalid); end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        while (!init_done && n < 2000) begin
            if (!bus.waitrequest) bad++;
            n++;
            @(negedge clk);
        end
        n_tests += 4;
        if (init_done !== 1'b1) begin n_fail++; $display("FAIL flight_init_done got %b want 1", init_done); end
        if (bad != 0) begin n_fail++; $display("FAIL flight_waitrequest got %0d low cycles want 0", bad); end
        if (obs_q.size() != 0) begin n_fail++; $display("FAIL flight_stale got %0d beats want 0", obs_q.size()); end
        if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL flight_err_cnt got %0d want 0", err_cnt); end
        issue(1'b0, 1'b1, BASE + 3, 2'b00, 16'h0, s);
        drain(ok);
        n_tests++;
        if (!ok || obs_q.size() != 1 || obs_q[0].d !== exp_q[0].d || obs_q[0].c != exp_q[0].c)
            begin n_fail++; $display("FAIL flight_recleared got %0d beats want 1 beat of %h", obs_q.size(), exp_q[0].d); end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        idle();
        test_reset();
        test_write_read();
        test_back_to_back();
        test_errors();
        test_random();
        test_reset_flight();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation exceeded 2 ms, want completion");
        $fatal(1);
    end
endmodule
